// File: rtl/fde_sequencer_pkg.sv
// Shared definitions for the miniCPU fetch/decode/execute sequencer:
// FSM state encoding and the opcodes the sequencer itself interprets.
package fde_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } fdeState_e;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_HALT = 4'hF;

endpackage

// File: rtl/fde_pc_reg.sv
// Program counter for the sequencer: async active-low clear, increment
// enable, natural wrap from 2**PC_W-1 back to 0.
module fde_pc_reg #(
  parameter int PC_W = 4
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            inc_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (inc_i) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fde_sequencer.sv
// Fetch/decode/execute sequencer for the miniCPU core: walks pc through
// instruction memory, decodes each word, drives the ALU and retires results.
module fde_sequencer
  import fde_sequencer_pkg::*;
#(
  parameter int PC_W   = 4,
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     stop_i,
  output logic                     imem_req_o,
  output logic [PC_W-1:0]          imem_addr_o,
  input  logic                     imem_valid_i,
  input  logic [OP_W+2*DATA_W-1:0] imem_rdata_i,
  output logic                     alu_start_o,
  input  logic                     alu_done_i,
  input  logic [DATA_W-1:0]        alu_result_i,
  output logic [OP_W-1:0]          opcode_o,
  output logic [DATA_W-1:0]        operand_1_o,
  output logic [DATA_W-1:0]        operand_2_o,
  output logic [DATA_W-1:0]        result_o,
  output logic [PC_W-1:0]          pc_o,
  output logic                     retire_o,
  output logic                     halted_o
);

  localparam int INSTR_W = OP_W + 2 * DATA_W;

  fdeState_e state_q, state_d;

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [OP_W-1:0]    opcode_q, opcode_d;
  logic [DATA_W-1:0]  operand1_q, operand1_d;
  logic [DATA_W-1:0]  operand2_q, operand2_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               aluStarted_q;
  logic               pcInc;

  logic [OP_W-1:0]   instrOp;
  logic [DATA_W-1:0] instrOperand1;
  logic [DATA_W-1:0] instrOperand2;

  assign instrOp       = instr_q[INSTR_W-1 -: OP_W];
  assign instrOperand1 = instr_q[2*DATA_W-1 -: DATA_W];
  assign instrOperand2 = instr_q[DATA_W-1:0];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // stop is only honoured at instruction boundaries (IDLE and WB).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   state_d = stop_i ? ST_IDLE : ST_FETCH;
      ST_FETCH:  if (imem_valid_i) state_d = ST_DECODE;
      ST_DECODE: begin
        if (instrOp == OP_W'(OPC_HALT)) begin
          state_d = ST_HALT;
        end else if (instrOp == OP_W'(OPC_NOP)) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC:   if (alu_done_i) state_d = ST_WB;
      ST_WB:     state_d = stop_i ? ST_IDLE : ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req_o  = (state_q == ST_FETCH);
    alu_start_o = (state_q == ST_EXEC) && !aluStarted_q;
    retire_o    = (state_q == ST_WB);
    halted_o    = (state_q == ST_HALT);
    pcInc       = (state_q == ST_WB);
  end

  always_comb begin
    instr_d    = instr_q;
    opcode_d   = opcode_q;
    operand1_d = operand1_q;
    operand2_d = operand2_q;
    result_d   = result_q;
    if (state_q == ST_FETCH && imem_valid_i) begin
      instr_d = imem_rdata_i;
    end
    if (state_q == ST_DECODE) begin
      opcode_d   = instrOp;
      operand1_d = instrOperand1;
      operand2_d = instrOperand2;
    end
    if (state_q == ST_EXEC && alu_done_i) begin
      result_d = alu_result_i;
    end
  end

  // aluStarted_q is high from the second EXEC cycle on, so the start is a single pulse.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      instr_q      <= '0;
      opcode_q     <= '0;
      operand1_q   <= '0;
      operand2_q   <= '0;
      result_q     <= '0;
      aluStarted_q <= 1'b0;
    end else begin
      instr_q      <= instr_d;
      opcode_q     <= opcode_d;
      operand1_q   <= operand1_d;
      operand2_q   <= operand2_d;
      result_q     <= result_d;
      aluStarted_q <= (state_q == ST_EXEC);
    end
  end

  fde_pc_reg #(
    .PC_W(PC_W)
  ) uPcReg (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .inc_i   (pcInc),
    .pc_o    (pc_o)
  );

  assign imem_addr_o = pc_o;
  assign opcode_o    = opcode_q;
  assign operand_1_o = operand1_q;
  assign operand_2_o = operand2_q;
  assign result_o    = result_q;

endmodule

// File: tb/tb_fde_sequencer.sv
// Directed self-checking bench for fde_sequencer with a small instruction
// memory and an ALU whose completion latency can be dialled per test.
module tb_fde_sequencer;

  logic        clk = 1'b0;
  logic        resetN;
  logic        stop;
  logic        imemReq;
  logic [3:0]  imemAddr;
  logic        imemValid;
  logic [19:0] imemRdata;
  logic        aluStart;
  logic        aluDone;
  logic [7:0]  aluResult;
  logic [3:0]  opcode;
  logic [7:0]  operand1;
  logic [7:0]  operand2;
  logic [7:0]  result;
  logic [3:0]  pc;
  logic        retire;
  logic        halted;

  logic [19:0] mem [16];
  logic        memStall;
  int          aluDelay;
  int          aluCnt;
  int          checkCount;
  int          errorCount;

  always #5 clk = ~clk;

  fde_sequencer dut (
    .clk_i       (clk),
    .reset_ni    (resetN),
    .stop_i      (stop),
    .imem_req_o  (imemReq),
    .imem_addr_o (imemAddr),
    .imem_valid_i(imemValid),
    .imem_rdata_i(imemRdata),
    .alu_start_o (aluStart),
    .alu_done_i  (aluDone),
    .alu_result_i(aluResult),
    .opcode_o    (opcode),
    .operand_1_o (operand1),
    .operand_2_o (operand2),
    .result_o    (result),
    .pc_o        (pc),
    .retire_o    (retire),
    .halted_o    (halted)
  );

  // Memory answers in the request cycle unless stalled.
  assign imemRdata = mem[imemAddr];
  assign imemValid = imemReq && !memStall;

  // ALU model: delay 0 completes with the start pulse, otherwise aluDelay cycles later.
  always @(posedge clk) begin
    if (aluStart && aluDelay != 0) aluCnt <= aluDelay;
    else if (aluCnt != 0) aluCnt <= aluCnt - 1;
  end
  assign aluDone = (aluDelay == 0) ? aluStart : (aluCnt == 1);
  always_comb begin
    case (opcode)
      4'h1:    aluResult = operand1 + operand2;
      4'h2:    aluResult = operand1 - operand2;
      default: aluResult = operand1 ^ operand2;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic stopVal, input logic stallVal);
    stop     = stopVal;
    memStall = stallVal;
  endtask

  task automatic waitFetch();
    int n;
    n = 0;
    while (!imemReq && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput("fetchReq", imemReq, 1);
  endtask

  // Runs one instruction from fetch to retire, checking address, latency, result and pc.
  task automatic runInstr(input logic [3:0] expPc, input logic [7:0] expResult,
                          input int expCycles);
    int n;
    logic [3:0] nextPc;
    nextPc = expPc + 4'd1;
    waitFetch();
    checkOutput("fetchAddr", imemAddr, expPc);
    n = 1;
    while (!retire && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput("retire", retire, 1);
    checkOutput("latency", n, expCycles);
    checkOutput("result", result, expResult);
    stepCycle();
    checkOutput("pcNext", pc, nextPc);
    checkOutput("retirePulse", retire, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] expRes;
    int n;
    checkCount = 0;
    errorCount = 0;
    aluDelay   = 0;
    aluCnt     = 0;
    for (int i = 0; i < 16; i++) mem[i] = {4'h1, 8'(i), 8'h20};
    mem[0] = 20'h1_03_05;
    mem[5] = 20'h0_AA_BB;
    mem[9] = 20'h2_50_09;

    // Test 1: reset then hold in IDLE with stop asserted
    resetN = 1'b0;
    applyStimulus(1'b1, 1'b0);
    #2;
    checkOutput("rstPc", pc, 0);
    checkOutput("rstReq", imemReq, 0);
    #8;
    resetN = 1'b1;
    for (int i = 0; i < 9; i++) stepCycle();
    checkOutput("idleReq", imemReq, 0);
    checkOutput("idlePc", pc, 0);
    checkOutput("idleOpcode", opcode, 0);
    checkOutput("idleResult", result, 0);
    checkOutput("idleRetire", retire, 0);
    checkOutput("idleHalted", halted, 0);
    checkOutput("idleAluStart", aluStart, 0);

    // Test 2: single ADD 3+5
    applyStimulus(1'b0, 1'b0);
    stepCycle();
    checkOutput("addFetchReq", imemReq, 1);
    checkOutput("addFetchAddr", imemAddr, 0);
    stepCycle();
    checkOutput("addDecodeStart", aluStart, 0);
    stepCycle();
    checkOutput("addExecStart", aluStart, 1);
    checkOutput("addOpcode", opcode, 4'h1);
    checkOutput("addOperand1", operand1, 8'h03);
    checkOutput("addOperand2", operand2, 8'h05);
    stepCycle();
    checkOutput("addRetire", retire, 1);
    checkOutput("addResult", result, 8'h08);
    stepCycle();
    checkOutput("addPc", pc, 1);
    checkOutput("addRetireDrop", retire, 0);

    // Test 3: remaining 15 instructions, then wrap to address 0
    expRes = 8'h08;
    for (int i = 1; i < 16; i++) begin
      if (i == 5) begin
        runInstr(4'(i), expRes, 3);
      end else if (i == 9) begin
        expRes = 8'h47;
        runInstr(4'(i), expRes, 4);
      end else begin
        expRes = 8'(i) + 8'h20;
        runInstr(4'(i), expRes, 4);
      end
    end
    runInstr(4'd0, 8'h08, 4);

    // Test 4: stop raised during a slow EXEC
    aluDelay = 3;
    mem[2]   = 20'hF_00_00;
    waitFetch();
    checkOutput("slowAddr", imemAddr, 1);
    stepCycle();
    stepCycle();
    checkOutput("slowStart", aluStart, 1);
    stop = 1'b1;
    stepCycle();
    checkOutput("slowStartPulse", aluStart, 0);
    checkOutput("slowNoRetire", retire, 0);
    n = 0;
    while (!retire && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput("slowWait", n, 3);
    checkOutput("slowResult", result, 8'h21);
    stepCycle();
    checkOutput("stopPc", pc, 2);
    checkOutput("stopReq", imemReq, 0);
    for (int i = 0; i < 3; i++) stepCycle();
    checkOutput("stopHoldReq", imemReq, 0);
    checkOutput("stopHoldPc", pc, 2);
    aluDelay = 0;
    stop     = 1'b0;

    // Test 5: HALT at address 2
    waitFetch();
    checkOutput("haltAddr", imemAddr, 2);
    stepCycle();
    checkOutput("haltDecode", halted, 0);
    stepCycle();
    checkOutput("halted", halted, 1);
    checkOutput("haltOpcode", opcode, 4'hF);
    for (int i = 0; i < 6; i++) begin
      stop = (i % 2 == 0);
      stepCycle();
      checkOutput("haltHold", halted, 1);
      checkOutput("haltReq", imemReq, 0);
      checkOutput("haltRetire", retire, 0);
      checkOutput("haltPc", pc, 2);
    end
    resetN = 1'b0;
    #2;
    checkOutput("haltRstPc", pc, 0);
    checkOutput("haltRstHalted", halted, 0);
    checkOutput("haltRstOpcode", opcode, 0);
    checkOutput("haltRstResult", result, 0);
    #3;
    applyStimulus(1'b0, 1'b0);
    resetN = 1'b1;

    // Test 6: reset while a fetch is stalled
    runInstr(4'd0, 8'h08, 4);
    memStall = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("stallReq", imemReq, 1);
    checkOutput("stallAddr", imemAddr, 1);
    checkOutput("stallRetire", retire, 0);
    resetN = 1'b0;
    #1;
    checkOutput("abortReq", imemReq, 0);
    checkOutput("abortPc", pc, 0);
    checkOutput("abortResult", result, 0);
    checkOutput("abortRetire", retire, 0);
    #2;
    applyStimulus(1'b1, 1'b0);
    resetN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("postAbortRetire", retire, 0);
      checkOutput("postAbortReq", imemReq, 0);
      checkOutput("postAbortPc", pc, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
